// File: rtl/first_move_gen.sv
// first_move_gen: turns a sampled 8-bit random counter value into the opening
// stone coordinates (1-based x,y) inside a centred window of the board.
// The low nibble selects the column and the high nibble selects the row. Each
// nibble is folded into 0..SPAN-1 by repeated subtraction, one step per cycle.
// A single registered o_valid pulse announces each new result.
module first_move_gen #(
    parameter int BOARD_SIZE = 19,
    parameter int SPAN       = 7
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_rand,
    output logic       o_busy,
    output logic       o_valid,
    output logic [4:0] o_x,
    output logic [4:0] o_y
);

    // The window is centred, so it begins OFFSET squares in from the edge.
    // The first coordinate inside the window is OFFSET+1.
    localparam int         OFFSET   = (BOARD_SIZE - SPAN) / 2;
    localparam logic [4:0] SPAN_L   = 5'(SPAN);
    localparam logic [4:0] BASE_L   = 5'(OFFSET + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REDUCE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] rx_q, rx_d;
    logic [4:0] ry_q, ry_d;
    logic [4:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic       valid_q, valid_d;

    // The result is ready once both remainders have dropped below the span.
    logic       rx_done;
    logic       ry_done;

    assign rx_done = (rx_q < SPAN_L);
    assign ry_done = (ry_q < SPAN_L);

    // Next-state logic: accept a request in IDLE, then fold both remainders
    // down in parallel until both fit in the window.
    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only the accepting edge samples i_rand. Later changes to
                // i_rand have no effect on the pending result.
                if (i_start) begin
                    rx_d    = {1'b0, i_rand[3:0]};
                    ry_d    = {1'b0, i_rand[7:4]};
                    state_d = REDUCE;
                end
            end

            REDUCE: begin
                // i_start is ignored here: there is no queueing.
                if (rx_done && ry_done) begin
                    x_d     = BASE_L + rx_q;
                    y_d     = BASE_L + ry_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Subtract only when the operand is at least SPAN, so the
                    // unsigned 5-bit value never wraps.
                    if (!rx_done) begin
                        rx_d = rx_q - SPAN_L;
                    end
                    if (!ry_done) begin
                        ry_d = ry_q - SPAN_L;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything and drops any
    // request that is in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            rx_q    <= '0;
            ry_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign o_busy  = (state_q != IDLE);
    assign o_valid = valid_q;
    assign o_x     = x_q;
    assign o_y     = y_q;

endmodule

// File: tb/tb_first_move_gen.sv
// Directed bench for first_move_gen (BOARD_SIZE=19, SPAN=7, window 7..13).
module tb_first_move_gen;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_rand;
    logic       o_busy;
    logic       o_valid;
    logic [4:0] o_x;
    logic [4:0] o_y;

    int n_checks = 0;
    int n_errors = 0;

    first_move_gen #(.BOARD_SIZE(19), .SPAN(7)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_rand  (i_rand),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_x     (o_x),
        .o_y     (o_y)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse i_start with value r, then wait for o_valid.
    // lat counts cycles from the start cycle (start cycle = 0) to the o_valid
    // cycle, or is -1 on timeout. busy counts the cycles in which o_busy is
    // high. On return the caller is in the o_valid cycle, #1 after the edge.
    task automatic run_move(input logic [7:0] r, output int lat, output int busy,
                            output int x, output int y);
        i_rand  = r;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_rand  = 8'($urandom);
        lat  = 1;
        busy = 0;
        while (!o_valid && lat < 20) begin
            if (o_busy) busy++;
            @(posedge i_clk); #1;
            lat++;
        end
        if (!o_valid) lat = -1;
        x = int'(o_x);
        y = int'(o_y);
    endtask

    // Reference values use explicit modulo and divide, not stepwise folding.
    function automatic int ref_x(input logic [7:0] r);
        return 7 + (int'(r[3:0]) % 7);
    endfunction
    function automatic int ref_y(input logic [7:0] r);
        return 7 + (int'(r[7:4]) % 7);
    endfunction
    function automatic int ref_lat(input logic [7:0] r);
        int kx, ky;
        kx = int'(r[3:0]) / 7;
        ky = int'(r[7:4]) / 7;
        return 2 + ((kx > ky) ? kx : ky);
    endfunction

    int lat, busy, x, y, nv, vx, vy;
    logic [7:0] dv [4] = '{8'h00, 8'hFF, 8'h36, 8'h9E};
    int ex [4] = '{7, 8, 13, 7};
    int ey [4] = '{7, 8, 10, 9};
    int el [4] = '{2, 4, 2, 4};

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_rand = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_busy",  int'(o_busy),  0);
        check("reset_valid", int'(o_valid), 0);
        check("reset_x",     int'(o_x),     0);
        check("reset_y",     int'(o_y),     0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 4; i++) begin
            run_move(dv[i], lat, busy, x, y);
            check($sformatf("dir%0d_lat", i), lat, el[i]);
            check($sformatf("dir%0d_x", i), x, ex[i]);
            check($sformatf("dir%0d_y", i), y, ey[i]);
            check($sformatf("dir%0d_busy", i), busy, el[i] - 1);
            check($sformatf("dir%0d_busy_at_valid", i), int'(o_busy), 0);
            @(posedge i_clk); #1;
            check($sformatf("dir%0d_pulse_end", i), int'(o_valid), 0);
            check($sformatf("dir%0d_x_hold", i), int'(o_x), ex[i]);
            check($sformatf("dir%0d_y_hold", i), int'(o_y), ey[i]);
        end

        // A second start while busy must be ignored.
        i_rand = 8'hFF; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_rand = 8'h00;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        nv = 0; vx = 0; vy = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_valid) begin
                nv++;
                vx = int'(o_x);
                vy = int'(o_y);
            end
            @(posedge i_clk); #1;
        end
        check("busy_restart_nvalid", nv, 1);
        check("busy_restart_x", vx, 8);
        check("busy_restart_y", vy, 8);

        // A reset pulse during REDUCE drops the request.
        i_rand = 8'hFF; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("rst_mid_busy_before", int'(o_busy), 1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid) nv++;
            @(posedge i_clk); #1;
        end
        check("rst_mid_nvalid", nv, 0);
        check("rst_mid_x", int'(o_x), 0);
        check("rst_mid_y", int'(o_y), 0);
        check("rst_mid_busy", int'(o_busy), 0);

        // Back-to-back: a new start in the o_valid cycle is accepted.
        run_move(8'h36, lat, busy, x, y);
        check("b2b_first_x", x, 13);
        run_move(8'h11, lat, busy, x, y);
        check("b2b_lat", lat, 2);
        check("b2b_x", x, 8);
        check("b2b_y", y, 8);
        @(posedge i_clk); #1;

        // Sweep all 256 input values against the modulo reference model.
        for (int v = 0; v < 256; v++) begin
            run_move(8'(v), lat, busy, x, y);
            check($sformatf("sweep_%02h_lat", v), lat, ref_lat(8'(v)));
            check($sformatf("sweep_%02h_x", v), x, ref_x(8'(v)));
            check($sformatf("sweep_%02h_y", v), y, ref_y(8'(v)));
            check($sformatf("sweep_%02h_range", v),
                  int'(x >= 7 && x <= 13 && y >= 7 && y <= 13), 1);
            if (v % 3 == 0) begin
                @(posedge i_clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
